// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Must match the existing ALU decoder's aluop interpretation.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore decode of controller state into datapath control signals.
module mc_outdec
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  input  logic   wr_en_i,
  output ctl_t   ctl_o,
  output logic   pcen_o,
  output logic   instr_done_o
);

  always_comb begin
    ctl_o        = '0;
    instr_done_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctl_o.alusrcb = 2'b01;
        // Gated so nothing is written while reset is held.
        ctl_o.irwrite = mem_ready_i & wr_en_i;
        ctl_o.pcwrite = mem_ready_i & wr_en_i;
      end
      S_DECODE:  ctl_o.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        ctl_o.alusrca = 1'b1;
        ctl_o.alusrcb = 2'b10;
        ctl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD:   ctl_o.iord = 1'b1;
      S_MEMWB: begin
        ctl_o.memtoreg = 1'b1;
        ctl_o.regwrite = 1'b1;
        instr_done_o   = 1'b1;
      end
      S_MEMWR: begin
        ctl_o.iord     = 1'b1;
        ctl_o.memwrite = 1'b1;
        instr_done_o   = mem_ready_i;
      end
      S_EXECUTE: begin
        ctl_o.alusrca = 1'b1;
        ctl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctl_o.regdst   = 1'b1;
        ctl_o.regwrite = 1'b1;
        instr_done_o   = 1'b1;
      end
      S_BRANCH: begin
        ctl_o.alusrca = 1'b1;
        ctl_o.aluop   = ALUOP_SUB;
        ctl_o.pcsrc   = 2'b01;
        ctl_o.branch  = 1'b1;
        instr_done_o  = 1'b1;
      end
      S_ADDIWB: begin
        ctl_o.regwrite = 1'b1;
        instr_done_o   = 1'b1;
      end
      S_JUMP: begin
        ctl_o.pcsrc   = 2'b10;
        ctl_o.pcwrite = 1'b1;
        instr_done_o  = 1'b1;
      end
      default: ctl_o = '0;
    endcase
  end

  assign pcen_o = ctl_o.pcwrite | (ctl_o.branch & zero_i);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic, output decode.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state_q, state_d;
  ctl_t   ctl;
  logic   illegal_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Unknown encodings fall through to the FETCH default.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .wr_en_i      (reset_n),
    .ctl_o        (ctl),
    .pcen_o       (pcen),
    .instr_done_o (instr_done)
  );

  assign iord       = ctl.iord;
  assign irwrite    = ctl.irwrite;
  assign memwrite   = ctl.memwrite;
  assign memtoreg   = ctl.memtoreg;
  assign regdst     = ctl.regdst;
  assign regwrite   = ctl.regwrite;
  assign alusrca    = ctl.alusrca;
  assign pcwrite    = ctl.pcwrite;
  assign branch     = ctl.branch;
  assign alusrcb    = ctl.alusrcb;
  assign pcsrc      = ctl.pcsrc;
  assign aluop      = ctl.aluop;
  assign illegal_op = illegal_d & reset_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-vector checks.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite;
  logic       alusrca, pcwrite, branch, pcen, illegal_op, instr_done;
  logic [1:0] alusrcb, pcsrc, aluop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .pcwrite(pcwrite),
    .branch(branch), .pcen(pcen), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op), .instr_done(instr_done)
  );

  // {iord irwrite memwrite memtoreg regdst regwrite alusrca pcwrite branch pcen,
  //  alusrcb, pcsrc, aluop, illegal_op, instr_done}
  logic [17:0] ctl_obs;
  assign ctl_obs = {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
                    pcwrite, branch, pcen, alusrcb, pcsrc, aluop, illegal_op, instr_done};

  localparam logic [17:0] C_FETCH1 = 18'b0100000101_01_00_00_00;
  localparam logic [17:0] C_FETCH0 = 18'b0000000000_01_00_00_00;
  localparam logic [17:0] C_DECODE = 18'b0000000000_11_00_00_00;
  localparam logic [17:0] C_DECILL = 18'b0000000000_11_00_00_10;
  localparam logic [17:0] C_ADR    = 18'b0000001000_10_00_00_00;
  localparam logic [17:0] C_MEMRD  = 18'b1000000000_00_00_00_00;
  localparam logic [17:0] C_MEMWB  = 18'b0001010000_00_00_00_01;
  localparam logic [17:0] C_WRWAIT = 18'b1010000000_00_00_00_00;
  localparam logic [17:0] C_WRDONE = 18'b1010000000_00_00_00_01;
  localparam logic [17:0] C_EXEC   = 18'b0000001000_00_00_10_00;
  localparam logic [17:0] C_ALUWB  = 18'b0000110000_00_00_00_01;
  localparam logic [17:0] C_BRZ1   = 18'b0000001011_00_01_01_01;
  localparam logic [17:0] C_BRZ0   = 18'b0000001010_00_01_01_01;
  localparam logic [17:0] C_ADDIWB = 18'b0000010000_00_00_00_01;
  localparam logic [17:0] C_JUMP   = 18'b0000000101_00_10_00_01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are already set; check this cycle's state/outputs, then advance one edge.
  task automatic step(input string tag, input state_t s, input logic [17:0] c);
    #1;
    check({tag, ".state"}, 32'(dut.state_q), 32'(s));
    check({tag, ".ctl"}, 32'(ctl_obs), 32'(c));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst.state", 32'(dut.state_q), 32'(S_FETCH));
    check("rst.ctl", 32'(ctl_obs), 32'(C_FETCH0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // The first edge after release already had mem_ready=1, so we are in DECODE.
    op = OP_J;
    step("rst1.dec", S_DECODE, C_DECODE);
    step("rst1.j", S_JUMP, C_JUMP);

    // lw, with op scrambled after MEMADR to show it is ignored
    op = OP_LW;
    step("lw.f", S_FETCH, C_FETCH1);
    step("lw.d", S_DECODE, C_DECODE);
    step("lw.a", S_MEMADR, C_ADR);
    op = 6'b111111;
    step("lw.r", S_MEMRD, C_MEMRD);
    step("lw.wb", S_MEMWB, C_MEMWB);

    // sw with three wait cycles
    op = OP_SW;
    step("sw.f", S_FETCH, C_FETCH1);
    step("sw.d", S_DECODE, C_DECODE);
    step("sw.a", S_MEMADR, C_ADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw.wait", S_MEMWR, C_WRWAIT);
    mem_ready = 1'b1;
    step("sw.done", S_MEMWR, C_WRDONE);

    op = OP_RTYPE;
    step("r.f", S_FETCH, C_FETCH1);
    step("r.d", S_DECODE, C_DECODE);
    step("r.e", S_EXECUTE, C_EXEC);
    step("r.wb", S_ALUWB, C_ALUWB);

    op = OP_ADDI;
    step("addi.f", S_FETCH, C_FETCH1);
    step("addi.d", S_DECODE, C_DECODE);
    step("addi.e", S_ADDIEXEC, C_ADR);
    step("addi.wb", S_ADDIWB, C_ADDIWB);

    op = OP_BEQ; zero = 1'b1;
    step("beq1.f", S_FETCH, C_FETCH1);
    step("beq1.d", S_DECODE, C_DECODE);
    step("beq1.b", S_BRANCH, C_BRZ1);
    zero = 1'b0;
    step("beq0.f", S_FETCH, C_FETCH1);
    step("beq0.d", S_DECODE, C_DECODE);
    step("beq0.b", S_BRANCH, C_BRZ0);

    op = 6'b111111;
    step("ill.f", S_FETCH, C_FETCH1);
    step("ill.d", S_DECODE, C_DECILL);
    op = OP_J;
    step("j.f", S_FETCH, C_FETCH1);
    step("j.d", S_DECODE, C_DECODE);
    step("j.j", S_JUMP, C_JUMP);

    // FETCH stall
    mem_ready = 1'b0;
    step("fw.0", S_FETCH, C_FETCH0);
    step("fw.1", S_FETCH, C_FETCH0);
    mem_ready = 1'b1;
    op = OP_LW;
    step("fw.2", S_FETCH, C_FETCH1);
    step("lw2.d", S_DECODE, C_DECODE);
    step("lw2.a", S_MEMADR, C_ADR);
    #1;
    check("lw2.r.state", 32'(dut.state_q), 32'(S_MEMRD));
    // Abort in MEMRD: reset takes effect without waiting for a clock edge.
    reset_n = 1'b0; mem_ready = 1'b0;
    #1;
    check("abort.state", 32'(dut.state_q), 32'(S_FETCH));
    check("abort.ctl", 32'(ctl_obs), 32'(C_FETCH0));
    @(posedge clk); #1;
    check("abort.hold", 32'(ctl_obs), 32'(C_FETCH0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    step("rel.0", S_FETCH, C_FETCH0);
    step("rel.1", S_FETCH, C_FETCH0);
    mem_ready = 1'b1;
    step("rel.2", S_FETCH, C_FETCH1);
    step("rel.d", S_DECODE, C_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
